// File: rtl/decrypt_phase_seq_pkg.sv
// Shared definitions for the ROLLO decryption phase sequencer: FSM state
// encoding, shared-memory mux select codes and small decode helpers.
package decrypt_phase_seq_pkg;

  localparam int D_ITER = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SYN,
    S_RSR,
    S_HASH,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_SYN  = 3'd2;
  localparam logic [2:0] ST_RSR  = 3'd3;
  localparam logic [2:0] ST_HASH = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd7;

  // Memory-mux select seen by the datapath while the FSM sits in s.
  function automatic logic [2:0] status_of(input state_t s);
    case (s)
      S_MUL:   return ST_MUL;
      S_SYN:   return ST_SYN;
      S_RSR:   return ST_RSR;
      S_HASH:  return ST_HASH;
      S_ERR:   return ST_ERR;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == S_MUL) || (s == S_SYN) || (s == S_RSR) || (s == S_HASH);
  endfunction

endpackage

// File: rtl/decrypt_phase_seq_watchdog.sv
// Per-phase watchdog: counts busy cycles since the last phase entry and flags
// the cycle whose increment would carry the counter to all-ones.
module phase_watchdog #(
  parameter int WD_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WD_W-1:0] ALL_ONES = '1;
  localparam logic [WD_W-1:0] LIMIT    = ALL_ONES - WD_W'(1);

  logic [WD_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + WD_W'(1);
    end
  end

  // Independent of clear on purpose: clear is derived from the FSM's next
  // state, which in turn depends on expired.
  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/decrypt_phase_seq.sv
// Top-level phase sequencer for the ROLLO decryption datapath: launches the
// multiplier, syndrome-space generator, RSR eliminator and SHA3 in order.
module decrypt_phase_seq
  import decrypt_phase_seq_pkg::*;
#(
  parameter int ITER = D_ITER,
  parameter int IW   = 3,
  parameter int WD_W = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          gf2mz_start,
  input  logic          gf2mz_done,
  output logic          s1s2_start,
  input  logic          s1s2_done,
  output logic          rsr_start,
  input  logic          rsr_done,
  output logic          sha3_start,
  input  logic          sha3_done,
  output logic [2:0]    status,
  output logic [IW-1:0] iterate,
  output logic          mat_sel,
  output logic          is_last,
  output logic          busy,
  output logic          finish,
  output logic          error
);

  localparam logic [IW-1:0] K_LAST = IW'(ITER - 2);

  state_t        state, state_n;
  logic [IW-1:0] iterate_n;
  logic          error_n;
  logic          wd_clear, wd_expired;

  phase_watchdog #(.WD_W(WD_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (is_busy(state)),
    .expired (wd_expired)
  );

  assign wd_clear = (state_n != state);

  // NOTE: every variable written here gets its default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    iterate_n = iterate;
    error_n   = error;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n   = S_MUL;
          iterate_n = '0;
          error_n   = 1'b0;
        end
      end

      // A done coincident with its own start pulse is stale from a prior run.
      S_MUL: begin
        if (abort)                           state_n = S_IDLE;
        else if (gf2mz_done && !gf2mz_start) state_n = S_SYN;
        else if (wd_expired) begin
          state_n = S_ERR;
          error_n = 1'b1;
        end
      end

      S_SYN: begin
        if (abort)                         state_n = S_IDLE;
        else if (s1s2_done && !s1s2_start) state_n = S_RSR;
        else if (wd_expired) begin
          state_n = S_ERR;
          error_n = 1'b1;
        end
      end

      S_RSR: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (rsr_done && !rsr_start) begin
          if (iterate == K_LAST) begin
            state_n = S_HASH;
          end else begin
            state_n   = S_SYN;
            iterate_n = iterate + IW'(1);
          end
        end else if (wd_expired) begin
          state_n = S_ERR;
          error_n = 1'b1;
        end
      end

      S_HASH: begin
        if (abort)                         state_n = S_IDLE;
        else if (sha3_done && !sha3_start) state_n = S_DONE;
        else if (wd_expired) begin
          state_n = S_ERR;
          error_n = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so status, iterate and the
  // start pulses all change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      gf2mz_start <= 1'b0;
      s1s2_start  <= 1'b0;
      rsr_start   <= 1'b0;
      sha3_start  <= 1'b0;
      status      <= ST_IDLE;
      iterate     <= '0;
      mat_sel     <= 1'b0;
      is_last     <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      gf2mz_start <= (state_n == S_MUL)  && (state != S_MUL);
      s1s2_start  <= (state_n == S_SYN)  && (state != S_SYN);
      rsr_start   <= (state_n == S_RSR)  && (state != S_RSR);
      sha3_start  <= (state_n == S_HASH) && (state != S_HASH);
      status      <= status_of(state_n);
      iterate     <= iterate_n;
      mat_sel     <= (iterate_n != '0);
      is_last     <= (iterate_n == K_LAST);
      busy        <= is_busy(state_n);
      finish      <= (state == S_HASH) && (state_n == S_DONE);
      error       <= error_n;
    end
  end

endmodule

// File: tb/tb_decrypt_phase_seq.sv
// Self-checking bench for decrypt_phase_seq: a scoreboard of expected start /
// finish events plus directed checks on stray dones, abort, watchdog and reset.
module tb_decrypt_phase_seq;

  localparam int ITER = 6;
  localparam int IW   = 3;
  localparam int WD_W = 4;

  logic          clk, rst, start, abort;
  logic          gf2mz_start, s1s2_start, rsr_start, sha3_start;
  logic          gf2mz_done, s1s2_done, rsr_done, sha3_done;
  logic [2:0]    status;
  logic [IW-1:0] iterate;
  logic          mat_sel, is_last, busy, finish, error;

  logic [3:0] auto_en, auto_done, man_done;
  int         resp_cnt [4];

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];

  assign gf2mz_done = auto_done[0] | man_done[0];
  assign s1s2_done  = auto_done[1] | man_done[1];
  assign rsr_done   = auto_done[2] | man_done[2];
  assign sha3_done  = auto_done[3] | man_done[3];

  decrypt_phase_seq #(.ITER(ITER), .IW(IW), .WD_W(WD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .gf2mz_start (gf2mz_start),
    .gf2mz_done  (gf2mz_done),
    .s1s2_start  (s1s2_start),
    .s1s2_done   (s1s2_done),
    .rsr_start   (rsr_start),
    .rsr_done    (rsr_done),
    .sha3_start  (sha3_start),
    .sha3_done   (sha3_done),
    .status      (status),
    .iterate     (iterate),
    .mat_sel     (mat_sel),
    .is_last     (is_last),
    .busy        (busy),
    .finish      (finish),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event record: kind (0 mul,1 syn,2 rsr,3 hash,4 finish), status, k, mat_sel, is_last.
  function automatic logic [15:0] pack_evt(input int kind, input logic [2:0] st,
                                           input logic [IW-1:0] k);
    return {5'd0, 3'(kind), st, k, (k != '0), (int'(k) == ITER - 2)};
  endfunction

  task automatic push_run(input bit with_finish);
    exp_q.push_back(pack_evt(0, 3'd1, '0));
    for (int k = 0; k <= ITER - 2; k++) begin
      exp_q.push_back(pack_evt(1, 3'd2, IW'(k)));
      exp_q.push_back(pack_evt(2, 3'd3, IW'(k)));
    end
    exp_q.push_back(pack_evt(3, 3'd4, IW'(ITER - 2)));
    if (with_finish) exp_q.push_back(pack_evt(4, 3'd0, IW'(ITER - 2)));
  endtask

  // Scoreboard: every pulse seen on the DUT must match the head of the queue.
  always @(negedge clk) begin
    logic [4:0]  pulses;
    logic [15:0] head;
    if (!rst) begin
      pulses = {finish, sha3_start, rsr_start, s1s2_start, gf2mz_start};
      for (int k = 0; k < 5; k++) begin
        if (pulses[k]) begin
          check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            head = exp_q.pop_front();
            check($sformatf("pulse_kind%0d", k),
                  32'({5'd0, 3'(k), status, iterate, mat_sel, is_last}), 32'(head));
          end
        end
      end
    end
  end

  // Auto-responder: returns each enabled done five cycles after its start.
  always @(negedge clk) begin
    logic [3:0] starts;
    starts = {sha3_start, rsr_start, s1s2_start, gf2mz_start};
    for (int i = 0; i < 4; i++) begin
      auto_done[i] = 1'b0;
      if (rst) begin
        resp_cnt[i] = 0;
      end else if (starts[i] && auto_en[i]) begin
        resp_cnt[i] = 5;
      end else if (resp_cnt[i] > 0) begin
        resp_cnt[i] = resp_cnt[i] - 1;
        if (resp_cnt[i] == 0) auto_done[i] = 1'b1;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input int max_cycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (finish) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_pulse(input int idx, input int k, input int max_cycles, input string tag);
    bit seen;
    logic [3:0] starts;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      starts = {sha3_start, rsr_start, s1s2_start, gf2mz_start};
      if (starts[idx] && int'(iterate) == k) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    man_done = '0;
    auto_en  = 4'hf;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({gf2mz_start, s1s2_start, rsr_start, sha3_start, status, iterate,
               mat_sel, is_last, busy, finish, error}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_status", 32'(status), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Normal run
    push_run(1'b1);
    pulse_start();
    check("run1_busy", 32'(busy), 32'd1);
    wait_finish(300, "run1_finish");
    check("run1_done_status", 32'(status), 32'd0);
    check("run1_done_busy", 32'(busy), 32'd0);

    // Stray dones: gf2mz_done with its own start, rsr_done while in MUL
    auto_en[0] = 1'b0;
    push_run(1'b1);
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    man_done[0] = 1'b1;
    @(negedge clk);
    man_done[0] = 1'b0;
    man_done[2] = 1'b1;
    @(negedge clk);
    man_done[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_still_mul", 32'(status), 32'd1);
    check("stray_still_busy", 32'(busy), 32'd1);
    man_done[0] = 1'b1;
    @(negedge clk);
    man_done[0] = 1'b0;
    auto_en[0]  = 1'b1;
    check("stray_then_syn", 32'(status), 32'd2);
    wait_finish(300, "stray_finish");

    // Start held high through a run, then relaunch from DONE
    push_run(1'b1);
    push_run(1'b1);
    start = 1'b1;
    wait_finish(300, "held_finish1");
    @(negedge clk);
    check("held_restart_status", 32'(status), 32'd1);
    check("held_restart_iter", 32'(iterate), 32'd0);
    wait_finish(300, "held_finish2");
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_idle_status", 32'(status), 32'd0);

    // Watchdog on a hung hash
    auto_en[3] = 1'b0;
    push_run(1'b0);
    pulse_start();
    wait_pulse(3, ITER - 2, 300, "wd_hash_entry");
    repeat (14) @(negedge clk);
    check("wd_hash_cycle15", 32'(status), 32'd4);
    @(negedge clk);
    check("wd_err_status", 32'(status), 32'd7);
    check("wd_err_flag", 32'(error), 32'd1);
    check("wd_err_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("wd_err_sticky", 32'(error), 32'd1);
    auto_en[3] = 1'b1;
    push_run(1'b1);
    pulse_start();
    check("wd_restart_clears", 32'(error), 32'd0);
    check("wd_restart_status", 32'(status), 32'd1);
    wait_finish(300, "wd_restart_finish");

    // Abort in RSR at k=2, coincident with rsr_done
    exp_q.push_back(pack_evt(0, 3'd1, '0));
    for (int k = 0; k <= 2; k++) begin
      exp_q.push_back(pack_evt(1, 3'd2, IW'(k)));
      exp_q.push_back(pack_evt(2, 3'd3, IW'(k)));
    end
    pulse_start();
    wait_pulse(2, 2, 300, "abort_rsr_k2");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_status", 32'(status), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    push_run(1'b1);
    pulse_start();
    check("abort_restart_iter", 32'(iterate), 32'd0);
    wait_finish(300, "abort_restart_finish");

    // Asynchronous reset mid-SYN
    exp_q.push_back(pack_evt(0, 3'd1, '0));
    exp_q.push_back(pack_evt(1, 3'd2, '0));
    pulse_start();
    wait_pulse(1, 0, 100, "rst_syn_entry");
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs",
          32'({gf2mz_start, s1s2_start, rsr_start, sha3_start, status, iterate,
               mat_sel, is_last, busy, finish, error}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_status", 32'(status), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decrypt_phase_seq.md
Name: decrypt_phase_seq

Overview:
- Top-level phase sequencer for the ROLLO decryption datapath.
- Issues one-cycle start pulses, in order, to the GF(2^m)[z] multiplier, the syndrome-space generator, the row-echelon (RSR) eliminator and the SHA3 core, waiting on each block's done.
- Drives the shared-memory mux select (status), the iteration index, and the RSR mode controls.
- Adds a per-phase watchdog and a sticky error flag so a hung sub-block cannot stall the top silently.

Parameters:
ITER, 6, dim(F); RSR loop runs k = 0..ITER-2 (ITER >= 2)
IW, 3, width of iterate, >= clog2(ITER)
WD_W, 20, watchdog counter width; timeout = 2^WD_W - 1 cycles per phase

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a decryption; sampled only in IDLE, DONE or ERR
abort  in  1  return to IDLE from any busy state
gf2mz_start  out  1  one-cycle start to multiplier
gf2mz_done  in  1  multiplier done
s1s2_start  out  1  one-cycle start to syndrome-space generator
s1s2_done  in  1  generator done
rsr_start  out  1  one-cycle start to RSR eliminator
rsr_done  in  1  RSR done
sha3_start  out  1  one-cycle start to hash
sha3_done  in  1  hash done
status  out  3  0 idle, 1 mul, 2 syn, 3 rsr, 4 hash, 7 error
iterate  out  IW  current loop index k
mat_sel  out  1  0 when k==0 (2n-row matrix), else 1
is_last  out  1  1 when k==ITER-2
busy  out  1  high in MUL, SYN, RSR, HASH
finish  out  1  one-cycle pulse on successful completion
error  out  1  sticky watchdog flag

Behaviour:
- All outputs are registered. Reset value of every output is 0. iterate resets to 0 and the FSM resets to IDLE.
- States: IDLE, MUL, SYN, RSR, HASH, DONE, ERR.
- IDLE/DONE/ERR with start=1: next cycle enter MUL; gf2mz_start=1 for exactly that first cycle; iterate<=0; error<=0.
- MUL + gf2mz_done: -> SYN, s1s2_start pulse on the entry cycle.
- SYN + s1s2_done: -> RSR, rsr_start pulse on the entry cycle.
- RSR + rsr_done:
  - if k==ITER-2: -> HASH, sha3_start pulse on the entry cycle.
  - else: k<=k+1, -> SYN, s1s2_start pulse.
  - iterate updates on the same edge as the state change, so mat_sel and is_last are valid from the first cycle of the next phase.
- HASH + sha3_done: -> DONE; finish=1 for one cycle.
- DONE: waits for start; it is the same as IDLE except status holds 0.
- A done input is ignored unless it belongs to the current state. A done arriving in the same cycle as its start pulse is ignored, because it is treated as stale from the previous run.
- start while busy is ignored.
- abort in a busy state -> IDLE next cycle, with no start pulses and no finish. abort has priority over done inputs in the same cycle.
- Watchdog:
  - Counter clears on every state entry and increments each busy cycle.
  - On reaching all-ones without the expected done: -> ERR, error=1, status=7, busy=0.
  - error stays set until the next accepted start.
- status is the mux select for shared memories:
  - 1 routes S memory to the multiplier.
  - 2 routes S/S1S2 to the generator.
  - 3 routes S1S2 to RSR.
  - 4 routes S1S2 to SHA3.
  - status changes on the same edge as the start pulse.
- mat_sel = (iterate != 0); is_last = (iterate == ITER-2). Both are registered versions derived from next-state iterate.
- Asserting rst mid-operation immediately forces IDLE with all outputs 0. No pulses are emitted on reset release.

Decomposition:
- Shared package/define: state encoding, status codes (ST_IDLE=0, ST_MUL=1, ST_SYN=2, ST_RSR=3, ST_HASH=4, ST_ERR=7), ITER default (`D).
- One natural sub-module, phase_watchdog (WD_W counter with clear/enable/expired). Everything else lives in one FSM.

Test Plan:
- Normal run, ITER=6, each done returned 5 cycles after its start -> start sequence MUL, then (SYN,RSR)x5 with iterate 0..4, then HASH. mat_sel=0 only during k=0; is_last=1 only at k=4; exactly one finish pulse; status trace 1,2,3,2,3...,4,0.
- Stray done: rsr_done pulsed during MUL, and gf2mz_done on the same cycle as gf2mz_start -> both ignored; FSM stays in MUL until a later gf2mz_done.
- Start while busy: start held high through the whole run -> no restart; after finish, start (still high) in DONE launches a second run with iterate=0.
- Watchdog, WD_W=4: sha3_done never asserted -> after 15 HASH cycles status=7, error=1, busy=0. Next start clears error and gf2mz_start pulses.
- Abort during RSR with k=2, coincident with rsr_done -> IDLE, no s1s2_start, no finish, iterate reset to 0 on the next start.
- Async reset asserted mid-SYN without a clock edge -> all outputs 0 immediately; after release, no spurious start pulses.
